// File: rtl/mdu_seq_pkg.sv
// Shared definitions for the iterative RV64M multiply/divide sequencer:
// funct3 encodings, FSM states, widths and iteration counts.
// Optional feature macro (used by mdu_seq): YSYX_23060251_MDU_FAST_MUL_EN
package mdu_seq_pkg;

    localparam int XLEN_DEF  = 64;
    localparam int WLEN      = 32;
    localparam int ITER_XLEN = 64;
    localparam int ITER_W    = 32;
    localparam int CNT_W     = 7;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    // rs1 is treated as signed by mul, mulh, mulhsu, div and rem
    function automatic logic src1_signed(input mdu_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    // rs2 is treated as signed by mul, mulh, div and rem
    function automatic logic src2_signed(input mdu_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/mdu_seq_if.sv
// Request/response bundle between the execute stage and the multiply/divide
// sequencer. master = pipeline side, slave = sequencer side.
interface mdu_seq_if
    import mdu_seq_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
);
    logic            in_valid_i;
    logic            in_ready_o;
    logic [2:0]      op_i;
    logic            is_w_i;
    logic [XLEN-1:0] src1_i;
    logic [XLEN-1:0] src2_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [XLEN-1:0] res_o;

    modport master (
        output in_valid_i, op_i, is_w_i, src1_i, src2_i, out_ready_i,
        input  in_ready_o, out_valid_o, res_o
    );

    modport slave (
        input  in_valid_i, op_i, is_w_i, src1_i, src2_i, out_ready_i,
        output in_ready_o, out_valid_o, res_o
    );
endinterface

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate: turns signed operands into magnitudes
// and re-applies the result sign after the unsigned loop.
module mdu_sign_fix #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] val_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] val_o
);
    // Negate when requested, pass through otherwise
    always_comb begin
        val_o = neg_i ? (WIDTH'(0) - val_i) : val_i;
    end
endmodule

// File: rtl/mdu_seq.sv
// Iterative RV64M multiply/divide sequencer: radix-2 shift-add multiply and
// restoring shift-subtract divide over unsigned magnitudes, with sign fix-up
// when the result is captured. Defining YSYX_23060251_MDU_FAST_MUL_EN
// replaces the multiply loop with a single-cycle product at accept.
module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input logic      clock,
    input logic      reset,
    input logic      flush_i,
    mdu_seq_if.slave bus
);
    localparam int PW = 2 * XLEN;

    mdu_state_e      state_q, state_d;
    mdu_op_e         op_q, op_d;
    logic            is_w_q, is_w_d;
    logic            neg_a_q, neg_a_d;
    logic            neg_r_q, neg_r_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] res_q, res_d;

    mdu_op_e         in_op;
    logic            s1_signed, s2_signed, sign1, sign2;
    logic [XLEN-1:0] ext1, ext2, mag1, mag2, min_val;
    logic            div_zero, div_ovf, special, fast_hit, accept, last_iter;
    logic [PW-1:0]   fast_prod;

    logic [XLEN:0]   mul_sum, div_rext, div_diff;
    logic            div_ge;
    logic [PW-1:0]   acc_step;

    mdu_op_e         fmt_op;
    logic            fmt_w, fmt_neg_a, fmt_neg_r;
    logic [PW-1:0]   prod_raw, prod_fix;
    logic [XLEN-1:0] quo_fix, rem_fix, res_raw, res_fmt;

    // Decode the request: normalise W multiplies, extend operands, flag special divides
    always_comb begin
        in_op = mdu_op_e'(bus.op_i);
        if (bus.is_w_i && !bus.op_i[2]) begin
            in_op = OP_MUL;
        end
        s1_signed = src1_signed(in_op);
        s2_signed = src2_signed(in_op);
        ext1 = bus.src1_i;
        ext2 = bus.src2_i;
        if (bus.is_w_i) begin
            ext1 = {{(XLEN-WLEN){s1_signed & bus.src1_i[WLEN-1]}}, bus.src1_i[WLEN-1:0]};
            ext2 = {{(XLEN-WLEN){s2_signed & bus.src2_i[WLEN-1]}}, bus.src2_i[WLEN-1:0]};
        end
        sign1 = s1_signed & ext1[XLEN-1];
        sign2 = s2_signed & ext2[XLEN-1];
        min_val = bus.is_w_i ? {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}}
                             : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = in_op[2] & (ext2 == '0);
        div_ovf  = in_op[2] & ~in_op[0] & (ext1 == min_val) & (&ext2);
        special  = div_zero | div_ovf;
        accept    = (state_q == ST_IDLE) & bus.in_valid_i & ~flush_i;
        last_iter = (state_q == ST_CALC) & (cnt_q == CNT_W'(1));
    end

    mdu_sign_fix #(.WIDTH(XLEN)) u_mag1 (.val_i(ext1), .neg_i(sign1), .val_o(mag1));
    mdu_sign_fix #(.WIDTH(XLEN)) u_mag2 (.val_i(ext2), .neg_i(sign2), .val_o(mag2));

`ifdef YSYX_23060251_MDU_FAST_MUL_EN
    // Whole product in one cycle; every multiply goes straight to DONE
    always_comb begin
        fast_prod = PW'(mag1) * PW'(mag2);
        fast_hit  = ~in_op[2];
    end
`else
    // Multiplies always take the iterative loop
    always_comb begin
        fast_prod = '0;
        fast_hit  = 1'b0;
    end
`endif

    // One loop step: multiply shifts the accumulator right, divide shifts it left
    always_comb begin
        mul_sum  = {1'b0, acc_q[PW-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
        div_rext = {acc_q[PW-1:XLEN], acc_q[XLEN-1]};
        div_diff = div_rext - {1'b0, b_q};
        div_ge   = div_rext >= {1'b0, b_q};
        if (op_q[2]) begin
            acc_step = {(div_ge ? div_diff[XLEN-1:0] : div_rext[XLEN-1:0]),
                        acc_q[XLEN-2:0], div_ge};
        end else begin
            acc_step = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    // Pick the product source; a W multiply leaves its product 32 bits up
    always_comb begin
        fmt_op    = accept ? in_op : op_q;
        fmt_w     = accept ? bus.is_w_i : is_w_q;
        fmt_neg_a = accept ? (sign1 ^ sign2) : neg_a_q;
        fmt_neg_r = accept ? sign1 : neg_r_q;
        if (accept) begin
            prod_raw = fast_prod;
        end else if (is_w_q) begin
            prod_raw = {{WLEN{1'b0}}, acc_step[PW-1:WLEN]};
        end else begin
            prod_raw = acc_step;
        end
    end

    mdu_sign_fix #(.WIDTH(PW))   u_prod (.val_i(prod_raw), .neg_i(fmt_neg_a), .val_o(prod_fix));
    mdu_sign_fix #(.WIDTH(XLEN)) u_quo  (.val_i(acc_step[XLEN-1:0]), .neg_i(fmt_neg_a), .val_o(quo_fix));
    mdu_sign_fix #(.WIDTH(XLEN)) u_rem  (.val_i(acc_step[PW-1:XLEN]), .neg_i(fmt_neg_r), .val_o(rem_fix));

    // Select the architectural result, override special divides, sign-extend W results
    always_comb begin
        case (fmt_op)
            OP_MUL:                       res_raw = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: res_raw = prod_fix[PW-1:XLEN];
            OP_DIV, OP_DIVU:              res_raw = quo_fix;
            default:                      res_raw = rem_fix;
        endcase
        if (accept && div_zero) begin
            res_raw = in_op[1] ? ext1 : '1;
        end else if (accept && div_ovf) begin
            res_raw = in_op[1] ? '0 : ext1;
        end
        res_fmt = res_raw;
        if (fmt_w) begin
            res_fmt = {{(XLEN-WLEN){res_raw[WLEN-1]}}, res_raw[WLEN-1:0]};
        end
    end

    // Datapath next-state: load on accept, iterate in CALC, capture result on DONE entry
    always_comb begin
        op_d    = op_q;
        is_w_d  = is_w_q;
        neg_a_d = neg_a_q;
        neg_r_d = neg_r_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        if (accept) begin
            op_d    = in_op;
            is_w_d  = bus.is_w_i;
            neg_a_d = sign1 ^ sign2;
            neg_r_d = sign1;
            b_d     = mag2;
            if (in_op[2] && bus.is_w_i) begin
                acc_d = {{XLEN{1'b0}}, mag1[WLEN-1:0], {(XLEN-WLEN){1'b0}}};
            end else begin
                acc_d = {{XLEN{1'b0}}, mag1};
            end
            cnt_d = bus.is_w_i ? CNT_W'(ITER_W) : CNT_W'(ITER_XLEN);
            if (special || fast_hit) begin
                res_d = res_fmt;
            end
        end else if (state_q == ST_CALC) begin
            acc_d = acc_step;
            cnt_d = cnt_q - CNT_W'(1);
            if (last_iter && !flush_i) begin
                res_d = res_fmt;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            op_q    <= OP_MUL;
            is_w_q  <= 1'b0;
            neg_a_q <= 1'b0;
            neg_r_q <= 1'b0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            op_q    <= op_d;
            is_w_q  <= is_w_d;
            neg_a_q <= neg_a_d;
            neg_r_q <= neg_r_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; a flush wins over both acceptance and the output handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid_i) begin
                    state_d = (special || fast_hit) ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush_i) begin
            state_d = ST_IDLE;
        end
    end

    // FSM outputs are decoded from state only; the result comes from a register
    always_comb begin
        bus.in_ready_o  = (state_q == ST_IDLE);
        bus.out_valid_o = (state_q == ST_DONE);
        bus.res_o       = res_q;
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed self-checking bench for mdu_seq: multiply/divide results, latency,
// special divides, output hold, flush and mid-operation reset.
// Latency expectations follow YSYX_23060251_MDU_FAST_MUL_EN when defined.
`timescale 1ns/1ps
module tb_mdu_seq;

    localparam int XLEN = 64;
`ifdef YSYX_23060251_MDU_FAST_MUL_EN
    localparam int MUL_LAT  = 1;
    localparam int MULW_LAT = 1;
`else
    localparam int MUL_LAT  = 65;
    localparam int MULW_LAT = 33;
`endif
    localparam int DIV_LAT  = 65;
    localparam int DIVW_LAT = 33;
    localparam int SPEC_LAT = 1;
    localparam int MAX_WAIT = 200;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clock   = 1'b0;
    logic reset   = 1'b1;
    logic flush_i = 1'b0;
    int   errors  = 0;
    int   checks  = 0;
    int   lat;
    int   seen_valid;

    mdu_seq_if #(.XLEN(XLEN)) bus ();

    mdu_seq #(.XLEN(XLEN)) dut (
        .clock  (clock),
        .reset  (reset),
        .flush_i(flush_i),
        .bus    (bus)
    );

    // 10 ns clock
    always #5 clock = ~clock;

    // Hard stop in case a wait is never satisfied
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%h expected=0x%h", tag, observed, expected);
        end
    endtask

    // Present a request and return #1 after the edge that accepts it
    task automatic applyStimulus(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
        int guard;
        guard = 0;
        bus.op_i       = op;
        bus.is_w_i     = w;
        bus.src1_i     = a;
        bus.src2_i     = b;
        bus.in_valid_i = 1'b1;
        while (bus.in_ready_o !== 1'b1 && guard < MAX_WAIT) begin
            @(posedge clock); #1;
            guard++;
        end
        @(posedge clock); #1;
        bus.in_valid_i = 1'b0;
    endtask

    // Count edges from the accept edge (inclusive) until out_valid is seen
    task automatic wait_result(output int latency);
        latency = 1;
        while (bus.out_valid_o !== 1'b1 && latency < MAX_WAIT) begin
            @(posedge clock); #1;
            latency++;
        end
    endtask

    // One-cycle output handshake
    task automatic consume_result();
        bus.out_ready_i = 1'b1;
        @(posedge clock); #1;
        bus.out_ready_i = 1'b0;
    endtask

    // Full operation: issue, wait, check latency and result, then accept it
    task automatic run_op(input string tag, input logic [2:0] op, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp_res, input int exp_lat);
        int l;
        applyStimulus(op, w, a, b);
        wait_result(l);
        checkOutput({tag, "_lat"}, 64'(l), 64'(exp_lat));
        checkOutput({tag, "_res"}, bus.res_o, exp_res);
        consume_result();
    endtask

    initial begin
        bus.in_valid_i  = 1'b0;
        bus.op_i        = 3'b000;
        bus.is_w_i      = 1'b0;
        bus.src1_i      = '0;
        bus.src2_i      = '0;
        bus.out_ready_i = 1'b0;
        $display("[TB] mdu_seq directed run");

        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        checkOutput("reset_in_ready",  64'(bus.in_ready_o),  64'd1);
        checkOutput("reset_out_valid", 64'(bus.out_valid_o), 64'd0);
        checkOutput("reset_res",       bus.res_o,            64'd0);

        run_op("mul",      3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, MUL_LAT);
        run_op("mulhu",    3'b011, 1'b0, ONES, 64'd2, 64'd1, MUL_LAT);
        run_op("mulh",     3'b001, 1'b0, ONES, 64'd2, ONES, MUL_LAT);
        run_op("mulhsu",   3'b010, 1'b0, 64'd2, ONES, 64'd1, MUL_LAT);
        run_op("mulw",     3'b000, 1'b1, 64'hDEAD_BEEF_1234_5678, 64'hFFFF_FFFF_0000_0010,
               64'h0000_0000_2345_6780, MULW_LAT);
        run_op("mulhu_w",  3'b011, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, MULW_LAT);
        run_op("divw_ovf", 3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
               64'hFFFF_FFFF_8000_0000, SPEC_LAT);
        run_op("remw_ovf", 3'b110, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
               64'd0, SPEC_LAT);
        run_op("divu_zero", 3'b101, 1'b0, 64'd100, 64'd0, ONES, SPEC_LAT);
        run_op("remu_zero", 3'b111, 1'b0, 64'd100, 64'd0, 64'd100, SPEC_LAT);
        run_op("div",      3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, DIV_LAT);
        run_op("divuw",    3'b101, 1'b1, 64'h1234_5678_FFFF_FFFF, 64'd3, 64'h0000_0000_5555_5555, DIVW_LAT);
        run_op("remw",     3'b110, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, ONES, DIVW_LAT);

        // rem -7 / 2 with the consumer stalling for five cycles
        applyStimulus(3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
        checkOutput("rem_busy_in_ready", 64'(bus.in_ready_o), 64'd0);
        wait_result(lat);
        checkOutput("rem_lat", 64'(lat), 64'(DIV_LAT));
        checkOutput("rem_res", bus.res_o, ONES);
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            checkOutput("rem_hold_valid",    64'(bus.out_valid_o), 64'd1);
            checkOutput("rem_hold_in_ready", 64'(bus.in_ready_o),  64'd0);
            checkOutput("rem_hold_res",      bus.res_o,            ONES);
        end
        consume_result();
        checkOutput("rem_after_hs_valid",    64'(bus.out_valid_o), 64'd0);
        checkOutput("rem_after_hs_in_ready", 64'(bus.in_ready_o),  64'd1);

        // Flush a divide in its tenth CALC cycle
        applyStimulus(3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7);
        repeat (9) @(posedge clock);
        #1;
        flush_i = 1'b1;
        @(posedge clock); #1;
        flush_i = 1'b0;
        checkOutput("flush_in_ready",  64'(bus.in_ready_o),  64'd1);
        checkOutput("flush_out_valid", 64'(bus.out_valid_o), 64'd0);
        seen_valid = 0;
        repeat (70) begin
            @(posedge clock); #1;
            if (bus.out_valid_o === 1'b1) seen_valid++;
        end
        checkOutput("flush_no_result", 64'(seen_valid), 64'd0);
        run_op("divu_after_flush", 3'b101, 1'b0, 64'd100, 64'd7, 64'd14, DIV_LAT);

        // Reset in the middle of a remainder
        applyStimulus(3'b111, 1'b0, 64'd100, 64'd7);
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        checkOutput("midreset_in_ready",  64'(bus.in_ready_o),  64'd1);
        checkOutput("midreset_out_valid", 64'(bus.out_valid_o), 64'd0);
        checkOutput("midreset_res",       bus.res_o,            64'd0);
        run_op("remu_after_reset", 3'b111, 1'b0, 64'd100, 64'd7, 64'd2, DIV_LAT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mdu_seq.md
# mdu_seq

Iterative multi-cycle RV64M multiply/divide sequencer, sitting in the execute stage beside the single-cycle ALU. Accepts one operation per valid/ready handshake, runs a radix-2 shift-add (multiply) or restoring shift-subtract (divide) loop, and holds the 64-bit result until the consumer accepts it. Decode routes M-extension instructions here; writeback muxes its result with the ALU result.

## Interface
Parameters:
- XLEN, 64, datapath width; equals `ysyx_23060251_xlen`

Ports:
- clock  in  1  system clock; one clock domain
- reset  in  1  synchronous, active-high reset
- flush_i  in  1  abort the in-flight operation (pipeline redirect)
- in_valid_i  in  1  operation request
- in_ready_o  out  1  block can accept a request
- op_i  in  3  funct3: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu
- is_w_i  in  1  RV64 *W variant (mulw/divw/divuw/remw/remuw)
- src1_i  in  XLEN  rs1 value
- src2_i  in  XLEN  rs2 value
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts result
- res_o  out  XLEN  result

## Operation
- FSM states: IDLE, CALC, DONE. Reset → IDLE; reset values: in_ready_o=1, out_valid_o=0, res_o=0, counter=0.
- IDLE: in_ready_o=1. On in_valid_i: latch op, is_w, operands; go CALC, or DONE directly for special cases.
- Operand prep at accept: W ops use src[31:0], sign-extended for signed ops, zero-extended for unsigned. Signed operands are converted to magnitudes; result sign flags (quotient: sign1^sign2; remainder: sign1; product: per signedness of op) are latched.
- Iteration count N: 64 for XLEN ops, 32 for W ops. Counter loads N, decrements once per CALC cycle; CALC → DONE when counter reaches 1 in the current cycle.
- Multiply: 128-bit accumulator, one multiplier bit per cycle. mul/mulw take low 64 (low 32 for W); mulh/mulhsu/mulhu take high 64 after sign fix. is_w with op 001–011 is treated as mulw.
- Divide: 64-bit partial remainder, one quotient bit per cycle. Sign fix applied on DONE entry.
- Special cases (skip CALC, DONE next cycle): divisor zero → quotient all ones, remainder = dividend. Signed overflow (most-negative / −1, in 64- or 32-bit domain) → quotient = dividend, remainder 0.
- W results: bit 31 sign-extended to 64 bits for every W op.
- DONE: out_valid_o=1, res_o stable until out_ready_i; on handshake → IDLE.
- flush_i: any state → IDLE next cycle, out_valid_o=0, no result emitted. flush_i has priority over acceptance and over the output handshake in the same cycle.
- reset has priority over flush_i.

## Timing
- Accept→out_valid_o: N+1 cycles (65 XLEN, 33 W); special cases 1 cycle; fast multiply 1 cycle.
- in_ready_o low from the cycle after accept until the cycle after the output handshake; no back-to-back overlap (accept impossible in the handshake cycle).
- out_valid_o never drops without out_ready_i or flush_i/reset.
- res_o is registered; no combinational path from inputs to outputs except none (in_ready_o is state-decoded).

## Configuration
- `YSYX_23060251_MDU_FAST_MUL_EN` defined: multiply ops (op[2]=0) compute the full product with a single-cycle `*` at accept, go straight to DONE (latency 1); dividers unchanged.
- Undefined: all multiply ops use the iterative loop (latency N+1).

## Structure
- Shared package/defines header: funct3 op encodings, state encoding, XLEN and W-width constants, iteration counts.
- Sub-module `mdu_sign_fix`: combinational magnitude/negate helper used at operand prep and result fix-up; everything else in `mdu_seq`.

## Test plan
- mul 7 × −3 (src2=0xFFFF_FFFF_FFFF_FFFD) → res 0xFFFF_FFFF_FFFF_FFEB, out_valid exactly 65 cycles after accept (1 with FAST_MUL).
- mulhu 0xFFFF_FFFF_FFFF_FFFF × 2 → res 1; mulh same operands → 0xFFFF_FFFF_FFFF_FFFF.
- divw 0x0000_0000_8000_0000 / 0xFFFF_FFFF → overflow, res 0xFFFF_FFFF_8000_0000 after 1 cycle; remw → 0.
- divu 100 / 0 → 0xFFFF_FFFF_FFFF_FFFF; remu 100 / 0 → 100; both 1-cycle latency.
- rem −7 / 2 → −1 (0xFFFF…FFFF); hold out_ready_i low 5 cycles → res stable, in_ready low, then handshake → IDLE.
- Accept div, assert flush_i at CALC cycle 10 → IDLE next cycle, no out_valid; new request accepted; reset mid-CALC → all outputs at reset values.
